// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle 8-byte data-memory responder (slave end of the memory-stage request interface)
//
// Accepts one read or write request at a time over a valid/ready handshake, performs the
// access LATENCY edges later and returns a one-cycle response strobe with read data and an
// address-error flag. busy_o stalls the pipeline while a request is outstanding.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   req_valid_i  request present          req_ready_o  request accepted this cycle (IDLE)
//   req_write_i  1 = write, 0 = read      req_addr_i   byte address of the 8-byte access
//   req_wdata_i  write data               rsp_valid_o  one-cycle response strobe
//   rsp_rdata_o  read data (0 on writes and on errors)
//   rsp_error_o  address error            busy_o       request outstanding
//   rd_count_o / wr_count_o / err_count_o  saturating access counters (only with DMEM_STATS_EN)
//
// Optional feature macro: DMEM_STATS_EN
module dmem_responder #(
   parameter int MAX_SIZE = 2048,
   parameter int LATENCY  = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [63:0] req_addr_i,
   input  logic [63:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [63:0] rsp_rdata_o,
   output logic        rsp_error_o,
`ifdef DMEM_STATS_EN
   output logic [31:0] rd_count_o,
   output logic [31:0] wr_count_o,
   output logic [31:0] err_count_o,
`endif
   output logic        busy_o
);
   localparam int AW = $clog2(MAX_SIZE);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [7:0]  mem_q [MAX_SIZE];
   logic [AW-1:0] base;
   logic [63:0] mem_rd;
   logic        addr_err;
   logic        commit;
   assign base     = addr_q[AW-1:0];
   // full 64-bit compare so huge addresses cannot alias back into range
   assign addr_err = addr_q > 64'(MAX_SIZE - 8);
   assign commit   = (state_q == WAIT) && (cnt_q == 4'd0);
   always_comb begin
      mem_rd = '0;
      for (int k = 0; k < 8; k++) mem_rd[8*k +: 8] = mem_q[base + AW'(k)];
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (req_valid_i) begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
            write_d = req_write_i;
            addr_d  = req_addr_i;
            wdata_d = req_wdata_i;
         end
         WAIT: if (cnt_q == 4'd0) begin
            state_d = RESP;
            err_d   = addr_err;
            rdata_d = (write_q || addr_err) ? 64'd0 : mem_rd;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
   // memory contents survive reset; an aborted request never reaches commit since reset forces IDLE
   always_ff @(posedge clk_i) begin
      if (commit && write_q && !addr_err)
         for (int k = 0; k < 8; k++) mem_q[base + AW'(k)] <= wdata_q[8*k +: 8];
   end
   assign req_ready_o = state_q == IDLE;
   assign busy_o      = state_q != IDLE;
   assign rsp_valid_o = state_q == RESP;
   assign rsp_rdata_o = rdata_q;
   assign rsp_error_o = err_q;
`ifdef DMEM_STATS_EN
   logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, err_cnt_q, err_cnt_d;
   always_comb begin
      rd_cnt_d  = (commit && !write_q && rd_cnt_q != '1) ? rd_cnt_q + 32'd1 : rd_cnt_q;
      wr_cnt_d  = (commit && write_q && wr_cnt_q != '1) ? wr_cnt_q + 32'd1 : wr_cnt_q;
      err_cnt_d = (commit && addr_err && err_cnt_q != '1) ? err_cnt_q + 32'd1 : err_cnt_q;
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end
   assign rd_count_o  = rd_cnt_q;
   assign wr_count_o  = wr_cnt_q;
   assign err_count_o = err_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench for dmem_responder against a byte-array reference model
module tb_dmem_responder;
   localparam int MAX_SIZE = 2048;
   localparam int LAT      = 3;
   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_write_i = 1'b0;
   logic [63:0] req_addr_i = '0;
   logic [63:0] req_wdata_i = '0;
   logic        rsp_valid_o;
   logic [63:0] rsp_rdata_o;
   logic        rsp_error_o;
   logic        busy_o;
`ifdef DMEM_STATS_EN
   logic [31:0] rd_count_o, wr_count_o, err_count_o;
`endif
   int checks = 0;
   int errors = 0;
   logic [7:0] mem_m [MAX_SIZE];
   int rd_m = 0, wr_m = 0, err_m = 0;

   dmem_responder #(.MAX_SIZE(MAX_SIZE), .LATENCY(LAT)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
`ifdef DMEM_STATS_EN
      .rd_count_o(rd_count_o), .wr_count_o(wr_count_o), .err_count_o(err_count_o),
`endif
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   // {busy, ready, rsp_valid}
   function automatic logic [63:0] flags();
      return 64'({busy_o, req_ready_o, rsp_valid_o});
   endfunction

   function automatic logic [63:0] model_read(input logic [63:0] a);
      logic [63:0] r;
      for (int k = 0; k < 8; k++) r[8*k +: 8] = mem_m[int'(a) + k];
      return r;
   endfunction

   // issue one request from an IDLE sampling point (#1 after an edge) and follow it to the next IDLE
   task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d, output logic [63:0] obs);
      logic        e;
      logic [63:0] r;
      e = a > 64'(MAX_SIZE - 8);
      r = (w || e) ? 64'd0 : model_read(a);
      if (w && !e) for (int k = 0; k < 8; k++) mem_m[int'(a) + k] = d[8*k +: 8];
      if (w) wr_m++; else rd_m++;
      if (e) err_m++;
      check("req_ready", 64'(req_ready_o), 64'd1);
      req_valid_i = 1'b1;
      req_write_i = w;
      req_addr_i  = a;
      req_wdata_i = d;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      for (int c = 0; c < LAT; c++) begin
         check("wait_flags", flags(), 64'b100);
         @(posedge clk_i); #1;
      end
      check("rsp_flags", flags(), 64'b101);
      check("rsp_rdata", rsp_rdata_o, r);
      check("rsp_error", 64'(rsp_error_o), 64'(e));
      obs = rsp_rdata_o;
      @(posedge clk_i); #1;
      check("idle_flags", flags(), 64'b010);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_flags"}, flags(), 64'b010);
      check({tag, "_rdata"}, rsp_rdata_o, 64'd0);
      check({tag, "_error"}, 64'(rsp_error_o), 64'd0);
   endtask

   initial begin
      logic [63:0] obs, prev, a;
      #3;
      check_reset_outputs("reset");
      @(posedge clk_i); @(posedge clk_i); #3;
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;
      check_reset_outputs("post_reset");
      // give every byte a known value
      for (int i = 0; i < MAX_SIZE / 8; i++) do_req(1'b1, 64'(i * 8), {$urandom, $urandom}, obs);
      // write then read, little-endian layout
      do_req(1'b1, 64'h40, 64'h0123456789ABCDEF, obs);
      check("wr_rdata_zero", obs, 64'd0);
      do_req(1'b0, 64'h40, 64'd0, obs);
      check("rd_after_wr", obs, 64'h0123456789ABCDEF);
      do_req(1'b0, 64'h3F, 64'd0, obs);
      check("le_byte_40", 64'(obs[15:8]), 64'hEF);
      // boundary
      do_req(1'b0, 64'h7F8, 64'd0, obs);
      prev = obs;
      do_req(1'b0, 64'h7F9, 64'd0, obs);
      check("bound_rdata", obs, 64'd0);
      do_req(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, obs);
      // error write leaves memory untouched
      do_req(1'b1, 64'h800, 64'hFFFF, obs);
      do_req(1'b0, 64'h7F8, 64'd0, obs);
      check("err_wr_unchanged", obs, prev);
      // hold valid: LAT+1 busy cycles per request, re-accepted in the following IDLE cycle
      req_valid_i = 1'b1;
      req_write_i = 1'b0;
      req_addr_i  = 64'h40;
      for (int r = 0; r < 3; r++) begin
         check("hold_idle", flags(), 64'b010);
         @(posedge clk_i); #1;
         rd_m++;
         for (int c = 0; c <= LAT; c++) begin
            check("hold_busy", 64'({busy_o, req_ready_o}), 64'b10);
            if (c == LAT) check("hold_rdata", rsp_rdata_o, model_read(64'h40));
            check("hold_rsp", 64'(rsp_valid_o), 64'(c == LAT));
            @(posedge clk_i); #1;
         end
      end
      check("hold_end_idle", flags(), 64'b010);
      req_valid_i = 1'b0;
      // reset mid-write aborts the access
      prev = model_read(64'h10);
      req_valid_i = 1'b1;
      req_write_i = 1'b1;
      req_addr_i  = 64'h10;
      req_wdata_i = 64'hAAAA;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      @(posedge clk_i); #1;
      @(posedge clk_i); #3;
      rst_n_i = 1'b0;
      #1;
      check_reset_outputs("abort");
      @(posedge clk_i); #2;
      rst_n_i = 1'b1;
      rd_m = 0; wr_m = 0; err_m = 0;
      @(posedge clk_i); #1;
      for (int c = 0; c < LAT + 2; c++) begin
         check("abort_no_rsp", flags(), 64'b010);
         @(posedge clk_i); #1;
      end
      do_req(1'b0, 64'h10, 64'd0, obs);
      check("abort_old_data", obs, prev);
      // access counters after a fresh reset: 3 reads in total with the one above
      do_req(1'b0, 64'h100, 64'd0, obs);
      do_req(1'b1, 64'h200, {$urandom, $urandom}, obs);
      do_req(1'b1, 64'h900, 64'h1234, obs);
      do_req(1'b0, 64'h200, 64'd0, obs);
`ifdef DMEM_STATS_EN
      check("rd_count", 64'(rd_count_o), 64'd3);
      check("wr_count", 64'(wr_count_o), 64'd2);
      check("err_count", 64'(err_count_o), 64'd1);
`endif
      // random traffic
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0, 1: a = 64'($urandom_range(0, MAX_SIZE - 8));
            2: a = 64'($urandom_range(MAX_SIZE - 20, MAX_SIZE + 10));
            default: a = {$urandom, $urandom};
         endcase
         do_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, obs);
      end
`ifdef DMEM_STATS_EN
      check("rd_count_end", 64'(rd_count_o), 64'(rd_m));
      check("wr_count_end", 64'(wr_count_o), 64'(wr_m));
      check("err_count_end", 64'(err_count_o), 64'(err_m));
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
